room_fsm: RTL and testbench

- Navigation FSM for the adventure game: tracks the player's current room from one-cycle direction commands.
- Drives the sword-found strobe `sw` into the sword-tracking FSM and consumes its `v` (vorpal sword held) output.
- `room_fsm` and the sword FSM together form the complete game core.
- Reports win/death terminal status and a saturating count of room changes for the display logic.

---
 rtl/room_fsm.sv | 87 ++++++++
 tb/tb_room_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/room_fsm.sv
// Adventure-game navigation FSM: tracks the player's room from one-cycle
// direction commands and counts room changes for the display.
module room_fsm #(
    parameter int MOVE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              n,
    input  logic              s,
    input  logic              e,
    input  logic              w,
    input  logic              v,
    output logic [6:0]        room,
    output logic              sw,
    output logic              win,
    output logic              die,
    output logic [MOVE_W-1:0] moves
);

    typedef enum logic [6:0] {
        CAVE   = 7'b0000001,
        TUNNEL = 7'b0000010,
        RIVER  = 7'b0000100,
        STASH  = 7'b0001000,
        DEN    = 7'b0010000,
        VAULT  = 7'b0100000,
        GRAVE  = 7'b1000000
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       legal;
    logic       advance;

    assign cmd       = {n, s, e, w};
    assign cmd_valid = (cmd != '0) && ((cmd & (cmd - 4'd1)) == '0);

    always_comb begin
        state_nxt = state;
        legal     = 1'b1;
        case (state)
            CAVE: begin
                if (cmd_valid && e) state_nxt = TUNNEL;
            end
            TUNNEL: begin
                if (cmd_valid && w)      state_nxt = CAVE;
                else if (cmd_valid && s) state_nxt = RIVER;
            end
            RIVER: begin
                if (cmd_valid && n)      state_nxt = TUNNEL;
                else if (cmd_valid && w) state_nxt = STASH;
                else if (cmd_valid && e) state_nxt = DEN;
            end
            STASH: begin
                if (cmd_valid && e) state_nxt = RIVER;
            end
            // DEN always lasts exactly one cycle; v is sampled as it ends.
            DEN:   state_nxt = v ? VAULT : GRAVE;
            VAULT: state_nxt = VAULT;
            GRAVE: state_nxt = GRAVE;
            default: begin
                state_nxt = CAVE;
                legal     = 1'b0;
            end
        endcase
        advance = legal && (state_nxt != state);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= CAVE;
            moves <= '0;
        end else begin
            state <= state_nxt;
            if (advance && (moves != '1))
                moves <= moves + MOVE_W'(1);
        end
    end

    assign room = state;
    assign sw   = (state == STASH);
    assign win  = (state == VAULT);
    assign die  = (state == GRAVE);

endmodule

// File: tb/tb_room_fsm.sv
// Bench for room_fsm: table-driven directed vectors, a saturation sequence and
// randomized stimulus, all checked against a room-graph reference model.
module tb_room_fsm;

    logic clk = 1'b0;
    logic reset, n, s, e, w, v;
    logic [6:0] room8, room3;
    logic sw8, win8, die8, sw3, win3, die3;
    logic [7:0] moves8;
    logic [2:0] moves3;

    always #5 clk = ~clk;

    room_fsm #(.MOVE_W(8)) dut8 (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
        .room(room8), .sw(sw8), .win(win8), .die(die8), .moves(moves8)
    );

    room_fsm #(.MOVE_W(3)) dut3 (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
        .room(room3), .sw(sw3), .win(win3), .die(die3), .moves(moves3)
    );

    localparam logic [3:0] CN = 4'b1000, CS = 4'b0100, CE = 4'b0010, CW = 4'b0001, CX = 4'b0000;

    typedef struct {
        bit         rst_n;
        logic [3:0] nsew;
        bit         vv;
        logic [6:0] exp_room;
        int         exp_moves;
    } vec_t;

    vec_t vec_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Room ids 0..6 = CAVE..GRAVE; exits[room][dir] with dir 0..3 = n,s,e,w, -1 = no exit.
    int exits[7][4] = '{
        '{-1, -1,  1, -1},
        '{-1,  2, -1,  0},
        '{ 1, -1,  4,  3},
        '{-1, -1,  2, -1},
        '{-1, -1, -1, -1},
        '{-1, -1, -1, -1},
        '{-1, -1, -1, -1}
    };

    int c8 = 0, m8 = 0, c3 = 0, m3 = 0;

    function automatic void mstep(inout int cur, inout int mv, input int maxv,
                                  input bit rst_n, input logic [3:0] nsew, input bit vv);
        int nxt;
        int dir;
        if (!rst_n) begin
            cur = 0;
            mv  = 0;
            return;
        end
        nxt = cur;
        if (cur == 4) begin
            nxt = vv ? 5 : 6;
        end else if (cur < 4 && $countones(nsew) == 1) begin
            dir = 0;
            for (int i = 0; i < 4; i++) if (nsew[3-i]) dir = i;
            if (exits[cur][dir] >= 0) nxt = exits[cur][dir];
        end
        if (nxt != cur && mv < maxv) mv = mv + 1;
        cur = nxt;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input bit rst_n, input logic [3:0] nsew, input bit vv);
        reset = rst_n;
        {n, s, e, w} = nsew;
        v = vv;
        mstep(c8, m8, 255, rst_n, nsew, vv);
        mstep(c3, m3, 7, rst_n, nsew, vv);
        @(posedge clk);
        #1;
        chk("room8",  32'(room8),  32'(1) << c8);
        chk("sw8",    32'(sw8),    32'(c8 == 3));
        chk("win8",   32'(win8),   32'(c8 == 5));
        chk("die8",   32'(die8),   32'(c8 == 6));
        chk("moves8", 32'(moves8), 32'(m8));
        chk("room3",  32'(room3),  32'(1) << c3);
        chk("moves3", 32'(moves3), 32'(m3));
    endtask

    function automatic void add(bit r, logic [3:0] c, bit vv, logic [6:0] er, int em);
        vec_t t;
        t.rst_n = r; t.nsew = c; t.vv = vv; t.exp_room = er; t.exp_moves = em;
        vec_q.push_back(t);
    endfunction

    initial begin
        bit sword;
        bit rst_r;
        logic [3:0] cmd;
        bit vv;
        int prev;

        reset = 1'b0; n = 1'b0; s = 1'b0; e = 1'b0; w = 1'b0; v = 1'b0;

        // Reset and idle, then the short stash walk.
        add(0, CX, 0, 7'b0000001, 0);
        for (int i = 0; i < 5; i++) add(1, CX, 0, 7'b0000001, 0);
        add(1, CE, 0, 7'b0000010, 1);
        add(1, CS, 0, 7'b0000100, 2);
        add(1, CW, 0, 7'b0001000, 3);
        // Winning path continues: back to river, into den, sword held.
        add(1, CE, 1, 7'b0000100, 4);
        add(1, CE, 1, 7'b0010000, 5);
        for (int i = 0; i < 10; i++) add(1, CX, 1, 7'b0100000, 6);
        add(1, CN, 1, 7'b0100000, 6);
        add(1, CW, 0, 7'b0100000, 6);
        // Losing path without the sword.
        add(0, CE, 1, 7'b0000001, 0);
        add(1, CE, 0, 7'b0000010, 1);
        add(1, CS, 0, 7'b0000100, 2);
        add(1, CE, 0, 7'b0010000, 3);
        add(1, CX, 0, 7'b1000000, 4);
        add(1, CN, 0, 7'b1000000, 4);
        add(1, CS, 1, 7'b1000000, 4);
        add(1, CE, 0, 7'b1000000, 4);
        add(1, CW, 1, 7'b1000000, 4);
        // Invalid combined command and blocked direction in the river.
        add(0, CX, 0, 7'b0000001, 0);
        add(1, CE | CW, 0, 7'b0000001, 0);
        add(1, CE, 0, 7'b0000010, 1);
        add(1, CS, 0, 7'b0000100, 2);
        add(1, CN | CE, 0, 7'b0000100, 2);
        add(1, CS, 0, 7'b0000100, 2);
        add(1, 4'b1111, 0, 7'b0000100, 2);
        add(1, CW, 0, 7'b0001000, 3);
        add(1, CE, 0, 7'b0000100, 4);
        add(1, CN, 0, 7'b0000010, 5);

        foreach (vec_q[i]) begin
            tick(vec_q[i].rst_n, vec_q[i].nsew, vec_q[i].vv);
            chk("tbl_room",  32'(room8),  32'(vec_q[i].exp_room));
            chk("tbl_moves", 32'(moves8), 32'(vec_q[i].exp_moves));
        end

        // Saturation of the narrow counter, then reset while in TUNNEL.
        tick(0, CX, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1, CE, 0);
            tick(1, CW, 0);
        end
        chk("sat_moves3", 32'(moves3), 32'd7);
        chk("sat_moves8", 32'(moves8), 32'd20);
        tick(1, CE, 0);
        chk("sat_room3", 32'(room3), 32'b0000010);
        chk("sat_hold3", 32'(moves3), 32'd7);
        tick(0, CE, 0);
        chk("rst_room3", 32'(room3), 32'b0000001);
        chk("rst_moves3", 32'(moves3), 32'd0);

        // Random stimulus; v mostly comes from a simple sword tracker.
        sword = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 39) != 0);
            case ($urandom_range(0, 9))
                0, 1:    cmd = CX;
                2, 3:    cmd = 4'($urandom_range(0, 15));
                default: cmd = 4'b1000 >> $urandom_range(0, 3);
            endcase
            vv = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : sword;
            prev = c8;
            tick(rst_r, cmd, vv);
            sword = rst_r && (sword || prev == 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
